// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the digit-serial subtractor.
//   state_e   : controller states (IDLE, RUN, DONE)
//   cnt_width : width of the digit counter for a given digit count (min 1 bit)
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_sub_digit.sv
// Combinational DIGIT-bit borrow-ripple subtract slice:
//   {bout, diff} = x - y - bin
// Ports:
//   x    : minuend digit
//   y    : subtrahend digit
//   bin  : borrow into the least significant bit
//   diff : difference digit
//   bout : borrow out of the most significant bit
module sub_digit #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             bin,
    output logic [DIGIT-1:0] diff,
    output logic             bout
);

    logic [DIGIT:0] brw;

    always_comb begin
        brw    = '0;
        diff   = '0;
        brw[0] = bin;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            diff[i]  = x[i] ^ y[i] ^ brw[i];
            // Borrow when y beats x outright, or they tie and a borrow arrives.
            brw[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & brw[i]);
        end
        bout = brw[DIGIT];
    end

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: d = a - b - bi over WIDTH bits, DIGIT bits per clock,
// with a registered borrow between digits.
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   : operand handshake; a, b, bi sampled on acceptance
//   a, b, bi            : minuend, subtrahend, borrow-in
//   out_valid/out_ready : result handshake; result held until accepted
//   d, bo, ovf          : difference mod 2^WIDTH, unsigned borrow-out,
//                         two's-complement overflow
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bo,
    output logic             ovf
);

    localparam int unsigned      NDIG       = WIDTH / DIGIT;
    localparam int unsigned      CW         = cnt_width(NDIG);
    localparam logic [CW-1:0]    LAST       = CW'(NDIG - 1);
    localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({DIGIT{1'b1}});

    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_subtractor: WIDTH must be a nonzero multiple of DIGIT");
    end

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             brw_q, brw_d;
    logic             bo_q, bo_d;
    logic             ovf_q, ovf_d;

    logic [31:0]      shamt;
    logic [DIGIT-1:0] slice_x, slice_y, slice_diff;
    logic             slice_bout;
    logic [WIDTH-1:0] res_new;

    // Select digit k = cnt_q of each operand by shifting it down to bit 0.
    assign shamt   = 32'(cnt_q) * DIGIT;
    assign slice_x = DIGIT'(a_q >> shamt);
    assign slice_y = DIGIT'(b_q >> shamt);

    sub_digit #(.DIGIT(DIGIT)) u_digit (
        .x    (slice_x),
        .y    (slice_y),
        .bin  (brw_q),
        .diff (slice_diff),
        .bout (slice_bout)
    );

    // Merge the new digit into its slot of the result register.
    assign res_new = (res_q & ~(SLICE_MASK << shamt)) | (WIDTH'(slice_diff) << shamt);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        brw_d   = brw_q;
        bo_d    = bo_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    brw_d   = bi;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d = res_new;
                brw_d = slice_bout;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    bo_d    = slice_bout;
                    // Overflow only possible when operand signs differ.
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                              (res_new[WIDTH-1] != a_q[WIDTH-1]);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            brw_q   <= 1'b0;
            bo_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            brw_q   <= brw_d;
            bo_q    <= bo_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign d         = res_q;
    assign bo        = bo_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor, run in parallel for DIGIT = 4, 1, 8, 32.
// Each configuration has a transaction-level reference model (plain integer
// arithmetic plus an accept-cycle timestamp) and a per-cycle compare process.
module tb_serial_subtractor;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned NCFG  = 4;

    function automatic int unsigned dig_of(input int unsigned g);
        case (g)
            0:       return 4;
            1:       return 1;
            2:       return 8;
            default: return 32;
        endcase
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp    = 0;
    int unsigned n_bad    = 0;
    int unsigned done_cnt = 0;

    function automatic void chk(input int unsigned dg, input string nm,
                                input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL [DIGIT=%0d] %s: got %0h expected %0h", dg, nm, got, exp);
        end
    endfunction

    function automatic void chk_res(input int unsigned dg, input string nm,
                                    input logic [31:0] rd, input logic rbo, input logic rovf,
                                    input logic [31:0] ed, input logic ebo, input logic eovf);
        chk(dg, {nm, "_d"},   64'(rd),   64'(ed));
        chk(dg, {nm, "_bo"},  64'(rbo),  64'(ebo));
        chk(dg, {nm, "_ovf"}, 64'(rovf), 64'(eovf));
    endfunction

    // Reference: {ovf, bo, d} from unsigned and signed integer arithmetic.
    function automatic logic [33:0] ref_sub(input logic [31:0] x, input logic [31:0] y,
                                            input logic c);
        longint u, s, lo, hi;
        logic   r_bo, r_ovf;
        u     = longint'(x) - longint'(y) - longint'(c);
        s     = longint'($signed(x)) - longint'($signed(y)) - longint'(c);
        lo    = -(longint'(1) << (WIDTH - 1));
        hi    = (longint'(1) << (WIDTH - 1)) - 1;
        r_bo  = (u < 0);
        r_ovf = (s < lo) || (s > hi);
        return {r_ovf, r_bo, u[31:0]};
    endfunction

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int unsigned DG  = dig_of(g);
        localparam int unsigned ND  = WIDTH / DG;
        localparam int unsigned RCY = (ND > 3) ? 3 : ND - 1;

        logic             rst_n     = 1'b1;
        logic             in_valid  = 1'b0;
        logic             out_ready = 1'b0;
        logic             bi        = 1'b0;
        logic [WIDTH-1:0] a         = '0;
        logic [WIDTH-1:0] b         = '0;
        logic             in_ready, out_valid, bo, ovf;
        logic [WIDTH-1:0] d;

        logic [WIDTH-1:0] nxt_a  = '0;
        logic [WIDTH-1:0] nxt_b  = '0;
        logic             nxt_bi = 1'b0;

        serial_subtractor #(.WIDTH(WIDTH), .DIGIT(DG)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .a         (a),
            .b         (b),
            .bi        (bi),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .d         (d),
            .bo        (bo),
            .ovf       (ovf)
        );

        // Model: one outstanding operation, result due ND cycles after accept.
        bit          busy  = 1'b0;
        bit          fresh = 1'b1;
        int unsigned cyc   = 0;
        int unsigned acc   = 0;
        logic [33:0] exp_r = '0;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                busy  = 1'b0;
                fresh = 1'b1;
            end else begin
                if (busy) begin
                    if (cyc > acc + ND && out_ready) busy = 1'b0;
                end else if (in_valid) begin
                    busy  = 1'b1;
                    fresh = 1'b0;
                    acc   = cyc;
                    exp_r = ref_sub(a, b, bi);
                end
                cyc++;
            end
        end

        always @(posedge clk) begin
            #1;
            chk(DG, "in_ready",  64'(in_ready),  64'(!busy));
            chk(DG, "out_valid", 64'(out_valid), 64'(busy && cyc > acc + ND));
            if (busy && cyc > acc + ND) begin
                chk(DG, "d",   64'(d),   64'(exp_r[31:0]));
                chk(DG, "bo",  64'(bo),  64'(exp_r[32]));
                chk(DG, "ovf", 64'(ovf), 64'(exp_r[33]));
            end else if (fresh && !busy) begin
                chk(DG, "reset_d",   64'(d),   64'd0);
                chk(DG, "reset_bo",  64'(bo),  64'd0);
                chk(DG, "reset_ovf", 64'(ovf), 64'd0);
            end
        end

        task automatic op(input logic [31:0] ta, input logic [31:0] tb2, input logic tbi,
                          input int unsigned hold, input bit bp,
                          output logic [31:0] rd, output logic rbo, output logic rovf);
            int unsigned n, lat;
            @(negedge clk);
            a         = ta;
            b         = tb2;
            bi        = tbi;
            in_valid  = 1'b1;
            out_ready = 1'b0;
            n = 0;
            while (!in_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk(DG, "accept_in_time", 64'(n < 50), 64'd1);
            @(negedge clk);
            // Operand pins change freely once the operation is accepted.
            in_valid = 1'b0;
            a        = $urandom();
            b        = $urandom();
            bi       = 1'($urandom());
            lat = 0;
            while (!out_valid && lat < 100) begin
                chk(DG, "run_in_ready", 64'(in_ready), 64'd0);
                @(negedge clk);
                lat++;
            end
            chk(DG, "latency", 64'(lat), 64'(ND));
            rd   = d;
            rbo  = bo;
            rovf = ovf;
            repeat (hold) begin
                if (bp) begin
                    a        = nxt_a;
                    b        = nxt_b;
                    bi       = nxt_bi;
                    in_valid = 1'b1;
                end
                @(negedge clk);
                chk(DG, "hold_valid", 64'(out_valid), 64'd1);
                chk(DG, "hold_ready", 64'(in_ready),  64'd0);
                chk(DG, "hold_d",     64'(d),         64'(rd));
                chk(DG, "hold_bo",    64'(bo),        64'(rbo));
                chk(DG, "hold_ovf",   64'(ovf),       64'(rovf));
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            in_valid  = 1'b0;
            chk(DG, "post_ho_ready", 64'(in_ready),  64'd1);
            chk(DG, "post_ho_valid", 64'(out_valid), 64'd0);
        endtask

        initial begin : drive
            logic [31:0] rd;
            logic        rbo, rovf;
            int unsigned n;
            #1 rst_n = 1'b0;
            repeat (3) @(negedge clk);
            rst_n = 1'b1;

            op(32'h0000_0005, 32'h0000_0003, 1'b0, 0, 1'b0, rd, rbo, rovf);
            chk_res(DG, "basic", rd, rbo, rovf, 32'h0000_0002, 1'b0, 1'b0);
            op(32'h0000_0000, 32'h0000_0001, 1'b0, 0, 1'b0, rd, rbo, rovf);
            chk_res(DG, "underflow", rd, rbo, rovf, 32'hFFFF_FFFF, 1'b1, 1'b0);
            op(32'h0000_0005, 32'h0000_0005, 1'b1, 0, 1'b0, rd, rbo, rovf);
            chk_res(DG, "borrow_in", rd, rbo, rovf, 32'hFFFF_FFFF, 1'b1, 1'b0);
            op(32'h8000_0000, 32'h0000_0001, 1'b0, 0, 1'b0, rd, rbo, rovf);
            chk_res(DG, "sovf", rd, rbo, rovf, 32'h7FFF_FFFF, 1'b0, 1'b1);

            nxt_a  = 32'h0000_1000;
            nxt_b  = 32'h0000_0001;
            nxt_bi = 1'b1;
            op(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 5, 1'b1, rd, rbo, rovf);
            chk_res(DG, "backpressure", rd, rbo, rovf, 32'h4B4B_4B4B, 1'b0, 1'b1);
            op(nxt_a, nxt_b, nxt_bi, 0, 1'b0, rd, rbo, rovf);
            chk_res(DG, "after_bp", rd, rbo, rovf, 32'h0000_0FFE, 1'b0, 1'b0);

            // Abort an operation partway through RUN.
            @(negedge clk);
            a        = 32'hDEAD_BEEF;
            b        = 32'h0000_0001;
            bi       = 1'b0;
            in_valid = 1'b1;
            n = 0;
            while (!in_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            @(negedge clk);
            in_valid = 1'b0;
            repeat (RCY) @(negedge clk);
            #2 rst_n = 1'b0;
            #1;
            chk(DG, "abort_in_ready",  64'(in_ready),  64'd1);
            chk(DG, "abort_out_valid", 64'(out_valid), 64'd0);
            chk(DG, "abort_d",         64'(d),         64'd0);
            chk(DG, "abort_bo",        64'(bo),        64'd0);
            chk(DG, "abort_ovf",       64'(ovf),       64'd0);
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            op(32'h1234_5678, 32'h0000_0678, 1'b0, 0, 1'b0, rd, rbo, rovf);
            chk_res(DG, "post_reset", rd, rbo, rovf, 32'h1234_5000, 1'b0, 1'b0);

            for (int i = 0; i < 30; i++) begin
                nxt_a  = $urandom();
                nxt_b  = $urandom();
                nxt_bi = 1'($urandom());
                op($urandom(), $urandom(), 1'($urandom()), $urandom_range(0, 3),
                   1'($urandom()), rd, rbo, rovf);
            end
            done_cnt++;
        end
    end

    initial begin : supervisor
        int unsigned t;
        chk(0, "model_basic",     64'(ref_sub(32'h5, 32'h3, 1'b0)),
            64'({1'b0, 1'b0, 32'h0000_0002}));
        chk(0, "model_underflow", 64'(ref_sub(32'h0, 32'h1, 1'b0)),
            64'({1'b0, 1'b1, 32'hFFFF_FFFF}));
        chk(0, "model_borrow_in", 64'(ref_sub(32'h5, 32'h5, 1'b1)),
            64'({1'b0, 1'b1, 32'hFFFF_FFFF}));
        chk(0, "model_sovf",      64'(ref_sub(32'h8000_0000, 32'h1, 1'b0)),
            64'({1'b1, 1'b0, 32'h7FFF_FFFF}));
        t = 0;
        while (done_cnt < NCFG && t < 50000) begin
            @(posedge clk);
            t++;
        end
        chk(0, "all_done", 64'(done_cnt), 64'(NCFG));
        repeat (2) @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
